// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 panel scheduler: FSM state encoding and
// default panel geometry.
package hub75_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_WAIT_TX  = 3'd3,
    S_DISPLAY  = 3'd4
  } sched_state_t;

  localparam int HPIXEL_DEFAULT   = 64;
  localparam int VPIXEL_DEFAULT   = 64;
  localparam int BPP_DEFAULT      = 8;
  localparam int SEGMENTS_DEFAULT = 2;

endpackage

// File: rtl/hub75_bcm_timer.sv
// Binary-code-modulation on-time down-counter. Loaded with the number of
// OE-low cycles for the current bit-plane; done flags the final cycle.
module hub75_bcm_timer #(
  parameter int dcnt_w_p = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [dcnt_w_p-1:0] load_val,
  output logic                done
);

  logic [dcnt_w_p-1:0] cnt;

  // Load on request, otherwise count down to zero and hold there
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == dcnt_w_p'(1));

endmodule

// File: rtl/hub75_frame_sched.sv
// HUB75 frame scheduler: walks rows and bit-planes, hands each row/plane to
// the colour shifter, then enables the panel for a BCM-weighted time.
module hub75_frame_sched
  import hub75_pkg::*;
#(
  parameter int hpixel_p   = HPIXEL_DEFAULT,
  parameter int vpixel_p   = VPIXEL_DEFAULT,
  parameter int bpp_p      = BPP_DEFAULT,
  parameter int segments_p = SEGMENTS_DEFAULT,
  localparam int rows_p          = vpixel_p / segments_p,
  localparam int row_w_p         = $clog2(rows_p),
  localparam int addr_width_p    = $clog2(hpixel_p * vpixel_p),
  localparam int pix_bit_width_p = $clog2(bpp_p),
  localparam int dcnt_w_p        = 8 + bpp_p - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_enable,
  input  logic [7:0]                 i_base_time,
  input  logic                       i_tx_ready,
  output logic                       o_tx_start,
  output logic [addr_width_p-1:0]    o_init_addr,
  output logic [pix_bit_width_p-1:0] o_pix_bit,
  output logic [row_w_p-1:0]         o_row_addr,
  output logic                       o_oe_n,
  output logic                       o_frame_done,
  output logic                       o_busy
);

  localparam logic [row_w_p-1:0]         last_row = row_w_p'(rows_p - 1);
  localparam logic [pix_bit_width_p-1:0] last_bit = pix_bit_width_p'(bpp_p - 1);

  sched_state_t                state;
  logic [row_w_p-1:0]          row_q;
  logic [pix_bit_width_p-1:0]  bit_q;
  logic                        tmr_load;
  logic                        tmr_done;
  logic [dcnt_w_p-1:0]         tmr_val;

  // On-time for a plane: base time (zero treated as one) weighted by 2^bit.
  // Width 8+bpp-1 holds 255 << (bpp-1) exactly, so the shift never overflows.
  function automatic logic [dcnt_w_p-1:0] load_count(
    input logic [7:0]                 base,
    input logic [pix_bit_width_p-1:0] plane
  );
    logic [7:0] base_eff;
    base_eff   = (base == 8'd0) ? 8'd1 : base;
    load_count = dcnt_w_p'(base_eff) << plane;
  endfunction

  assign tmr_load = (state == S_WAIT_TX) && i_tx_ready;
  assign tmr_val  = load_count(i_base_time, bit_q);

  hub75_bcm_timer #(
    .dcnt_w_p (dcnt_w_p)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Scheduler FSM with registered outputs; OE is only driven low while the
  // next state is DISPLAY, so shifting and row changes are always blanked
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      row_q        <= '0;
      bit_q        <= '0;
      o_tx_start   <= 1'b0;
      o_init_addr  <= '0;
      o_pix_bit    <= '0;
      o_row_addr   <= '0;
      o_oe_n       <= 1'b1;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_tx_start   <= 1'b0;
      o_frame_done <= 1'b0;
      o_oe_n       <= 1'b1;
      case (state)
        S_IDLE: begin
          if (i_enable) begin
            row_q      <= '0;
            bit_q      <= '0;
            o_row_addr <= '0;
            o_busy     <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          if (i_tx_ready) begin
            o_tx_start  <= 1'b1;
            o_init_addr <= addr_width_p'(row_q) * addr_width_p'(hpixel_p);
            o_pix_bit   <= bit_q;
            state       <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (!i_tx_ready) begin
            state <= S_WAIT_TX;
          end
        end
        S_WAIT_TX: begin
          if (i_tx_ready) begin
            o_oe_n <= 1'b0;
            state  <= S_DISPLAY;
          end
        end
        S_DISPLAY: begin
          if (!tmr_done) begin
            o_oe_n <= 1'b0;
          end else if (bit_q != last_bit) begin
            bit_q <= bit_q + 1'b1;
            state <= S_START;
          end else if (row_q != last_row) begin
            bit_q      <= '0;
            row_q      <= row_q + 1'b1;
            o_row_addr <= row_q + 1'b1;
            state      <= S_START;
          end else begin
            o_frame_done <= 1'b1;
            bit_q        <= '0;
            row_q        <= '0;
            o_row_addr   <= '0;
            if (i_enable) begin
              state <= S_START;
            end else begin
              o_busy <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_frame_sched.sv
// Directed bench for hub75_frame_sched (64x64, 2 segments, 8 bpp) with a
// transmitter model whose ready drops one cycle after start for 10 cycles.
module tb_hub75_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_enable;
  logic [7:0]  i_base_time;
  logic        tx_ready;
  logic        o_tx_start;
  logic [11:0] o_init_addr;
  logic [2:0]  o_pix_bit;
  logic [4:0]  o_row_addr;
  logic        o_oe_n;
  logic        o_frame_done;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  logic        tx_en  = 1'b1;
  int          tx_cnt = 0;

  int n_tx = 0;
  int n_fd = 0;
  int run  = 0;
  int oe_bad  = 0;
  int row_bad = 0;
  logic [4:0] prev_row = '0;
  int widths[$];
  int rec_addr[$];
  int rec_row[$];
  int rec_pix[$];

  always #5 clk = ~clk;

  hub75_frame_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (i_enable),
    .i_base_time  (i_base_time),
    .i_tx_ready   (tx_ready),
    .o_tx_start   (o_tx_start),
    .o_init_addr  (o_init_addr),
    .o_pix_bit    (o_pix_bit),
    .o_row_addr   (o_row_addr),
    .o_oe_n       (o_oe_n),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy)
  );

  // Transmitter model: busy for 10 cycles starting one cycle after start
  always @(posedge clk) begin
    if (o_tx_start) tx_cnt <= 10;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign tx_ready = tx_en && (tx_cnt == 0);

  // Monitor: record start pulses, OE-low run lengths and blanking violations
  always @(posedge clk) begin
    #1;
    if (o_tx_start === 1'b1) begin
      rec_addr.push_back(int'(o_init_addr));
      rec_row.push_back(int'(o_row_addr));
      rec_pix.push_back(int'(o_pix_bit));
      n_tx++;
    end
    if (o_frame_done === 1'b1) n_fd++;
    if (o_oe_n === 1'b0) run++;
    else if (run > 0) begin
      widths.push_back(run);
      run = 0;
    end
    if (o_oe_n === 1'b0 && (o_tx_start || !tx_ready)) oe_bad++;
    if (o_oe_n === 1'b0 && o_row_addr !== prev_row) row_bad++;
    prev_row = o_row_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int k = 0;
    while (n_tx < n && k < budget) begin @(negedge clk); k++; end
    chk(tag, 32'(n_tx >= n), 1);
  endtask

  task automatic wait_fd(input int n, input int budget, input string tag);
    int k = 0;
    while (n_fd < n && k < budget) begin @(negedge clk); k++; end
    chk(tag, 32'(n_fd >= n), 1);
  endtask

  task automatic wait_w(input int n, input int budget, input string tag);
    int k = 0;
    while (widths.size() < n && k < budget) begin @(negedge clk); k++; end
    chk(tag, 32'(widths.size() >= n), 1);
  endtask

  initial begin
    int sum;
    int n0;
    int k;
    rst_n       = 1'b0;
    i_enable    = 1'b0;
    i_base_time = 8'd4;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx_start", 32'(o_tx_start), 0);
    chk("rst_oe_n", 32'(o_oe_n), 1);
    chk("rst_row_addr", 32'(o_row_addr), 0);
    chk("rst_init_addr", 32'(o_init_addr), 0);
    chk("rst_pix_bit", 32'(o_pix_bit), 0);
    chk("rst_frame_done", 32'(o_frame_done), 0);
    chk("rst_busy", 32'(o_busy), 0);

    // First row at base time 4
    rst_n    = 1'b1;
    i_enable = 1'b1;
    wait_tx(1, 50, "first_start_seen");
    chk("first_init_addr", 32'(o_init_addr), 0);
    chk("first_pix_bit", 32'(o_pix_bit), 0);
    chk("first_row_addr", 32'(o_row_addr), 0);
    chk("first_oe_n", 32'(o_oe_n), 1);
    chk("first_busy", 32'(o_busy), 1);

    wait_w(8, 3000, "row0_widths_seen");
    i_base_time = 8'd1;
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < widths.size()) begin
        chk($sformatf("row0_w%0d", i), 32'(widths[i]), 32'(4 << i));
        sum += widths[i];
      end
    end
    chk("row0_total", 32'(sum), 1020);

    // Row 5 bit 0, then the rest of the frame
    wait_tx(42, 5000, "row5_start_seen");
    chk("row5_init_addr", 32'(rec_addr[40]), 320);
    chk("row5_row_addr", 32'(rec_row[40]), 5);
    chk("row5_pix_bit", 32'(rec_pix[40]), 0);
    chk("row5_b1_pix_bit", 32'(rec_pix[41]), 1);
    chk("row5_b1_init_addr", 32'(rec_addr[41]), 320);

    wait_fd(1, 20000, "frame1_done_seen");
    chk("frame1_starts", 32'(n_tx), 256);
    chk("frame1_done_cnt", 32'(n_fd), 1);
    chk("row31_init_addr", 32'(rec_addr[248]), 1984);
    chk("row31_pix_bit", 32'(rec_pix[255]), 7);

    // Restart at row 0, then drop enable mid-frame
    wait_tx(257, 50, "restart_seen");
    chk("restart_init_addr", 32'(rec_addr[256]), 0);
    chk("restart_row_addr", 32'(rec_row[256]), 0);
    chk("restart_pix_bit", 32'(rec_pix[256]), 0);
    repeat (100) @(negedge clk);
    i_enable = 1'b0;
    wait_fd(2, 20000, "frame2_done_seen");
    repeat (20) @(negedge clk);
    chk("idle_busy", 32'(o_busy), 0);
    chk("idle_oe_n", 32'(o_oe_n), 1);
    chk("frame2_starts", 32'(n_tx), 512);
    chk("frame2_done_cnt", 32'(n_fd), 2);
    chk("oe_blank_violations", 32'(oe_bad), 0);
    chk("row_change_while_lit", 32'(row_bad), 0);

    // Base time 0 for planes 0..6, then 255 for plane 7
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    widths.delete();
    i_base_time = 8'd0;
    i_enable    = 1'b1;
    rst_n       = 1'b1;
    wait_w(7, 2000, "base0_widths_seen");
    i_base_time = 8'd255;
    chk("base0_w0", 32'(widths[0]), 1);
    chk("base0_w6", 32'(widths[6]), 64);
    wait_w(8, 40000, "base255_width_seen");
    i_base_time = 8'd4;
    chk("base255_w7", 32'(widths[7]), 32640);

    // Reset during DISPLAY of row 1
    k = 0;
    while (o_oe_n !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    chk("row1_display_seen", 32'(o_oe_n), 0);
    chk("row1_row_addr", 32'(o_row_addr), 1);
    rst_n = 1'b0;
    tx_en = 1'b0;
    @(negedge clk);
    chk("abort_oe_n", 32'(o_oe_n), 1);
    chk("abort_row_addr", 32'(o_row_addr), 0);
    chk("abort_busy", 32'(o_busy), 0);

    // Transmitter never ready: scheduler waits in START without a pulse
    n0 = n_tx;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("noready_starts", 32'(n_tx - n0), 0);
    chk("noready_busy", 32'(o_busy), 1);
    chk("noready_oe_n", 32'(o_oe_n), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hub75_frame_sched.md
HUB75_FRAME_SCHED -- requirements
Module: hub75_frame_sched

Interface
REQ-001 SHALL have parameters: hpixel_p, default 64, display width in pixels; vpixel_p, default 64, display height in pixels; bpp_p, default 8, bits per colour channel; segments_p, default 2, number of display segments.
REQ-002 SHALL have derived localparams: rows_p = vpixel_p/segments_p; row_w_p = $clog2(rows_p); addr_width_p = $clog2(hpixel_p*vpixel_p); pix_bit_width_p = $clog2(bpp_p); dcnt_w_p = 8+bpp_p-1.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port i_enable, input, 1, run frames continuously while high.
REQ-006 SHALL have port i_base_time, input, 8, number of OE-low cycles for bit-plane 0.
REQ-007 SHALL have port i_tx_ready, input, 1, ready from the colour shift transmitter.
REQ-008 SHALL have port o_tx_start, output, 1, one-cycle start pulse to the transmitter.
REQ-009 SHALL have port o_init_addr, output, addr_width_p, first pixel address of the row.
REQ-010 SHALL have port o_pix_bit, output, pix_bit_width_p, bit-plane to shift.
REQ-011 SHALL have port o_row_addr, output, row_w_p, panel row-select lines A..E.
REQ-012 SHALL have port o_oe_n, output, 1, panel output enable, active-low.
REQ-013 SHALL have port o_frame_done, output, 1, one-cycle pulse at the end of each frame.
REQ-014 SHALL have port o_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, START, WAIT_ACK, WAIT_TX, DISPLAY.
REQ-016 IDLE: o_oe_n=1; when i_enable=1, SHALL set row=0, bit=0 and go to START.
REQ-017 START: SHALL wait for i_tx_ready=1; in that cycle o_tx_start=1 for exactly one cycle, with o_init_addr=row*hpixel_p and o_pix_bit=bit held stable from this cycle until leaving WAIT_TX; next state is WAIT_ACK.
REQ-018 START with bit=0: o_row_addr SHALL update to row on START entry, while o_oe_n=1.
REQ-019 WAIT_ACK: SHALL wait for i_tx_ready=0, then go to WAIT_TX; o_tx_start SHALL be 0.
REQ-020 WAIT_TX: SHALL wait for i_tx_ready=1, then load the display counter with max(i_base_time,1) << bit and go to DISPLAY.
REQ-021 DISPLAY: o_oe_n=0 for exactly the loaded count of cycles; the counter is dcnt_w_p bits wide and SHALL never overflow.
REQ-022 End of DISPLAY, bit<bpp_p-1: SHALL increment bit and go to START.
REQ-023 End of DISPLAY, bit=bpp_p-1, row<rows_p-1: SHALL set bit=0, increment row and go to START.
REQ-024 End of DISPLAY, last row and last bit: SHALL pulse o_frame_done for one cycle and set row=0, bit=0; if i_enable=1 go to START, else go to IDLE.
REQ-025 i_enable SHALL be sampled only at frame boundaries; deasserting it mid-frame completes the current frame.
REQ-026 i_base_time SHALL be sampled at every WAIT_TX->DISPLAY transition.
REQ-027 o_oe_n SHALL be 1 in every state except DISPLAY, so the panel is blanked during shifting and row changes.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 When rst_n=0, SHALL go to IDLE with o_tx_start=0, o_oe_n=1, o_row_addr=0, o_init_addr=0, o_pix_bit=0, o_frame_done=0, o_busy=0, and the counters cleared.
REQ-030 Reset asserted mid-operation SHALL abort immediately; o_oe_n=1 on the next edge.

Structure
REQ-031 SHALL place the sched_state_t enum and the default geometry constants in the shared package hub75_pkg.
REQ-032 SHALL put the OE-low down-counter (load, count, done) in sub-module hub75_bcm_timer.

Verification (bench uses 64x64, 2 segments, bpp 8, with a transmitter model where ready drops 1 cycle after start and returns 10 cycles later)
REQ-033 Reset, then i_enable=1, i_base_time=4 -> first o_tx_start with o_init_addr=0, o_pix_bit=0, o_row_addr=0.
REQ-034 Same setup -> OE-low widths per row are 4,8,16,...,512; the row total is 1020 cycles.
REQ-035 Row 5, bit 0 start -> o_init_addr=320 and o_row_addr=5; o_oe_n=1 throughout every START, WAIT_ACK and WAIT_TX.
REQ-036 Full frame -> 256 tx_start pulses, one o_frame_done pulse, then restart at row 0; with i_enable dropped mid-frame, the frame completes, then IDLE and o_busy=0.
REQ-037 i_base_time=0 -> bit-0 display lasts 1 cycle; i_base_time=255, bit 7 -> 32640 cycles.
REQ-038 rst_n asserted during DISPLAY -> next cycle o_oe_n=1 and o_row_addr=0; i_tx_ready held 0 -> no o_tx_start pulse issued.
